clz_chunk_sequencer: RTL and testbench

- Iterative leading-zero counter for wide operands (default 64 bits) in the execution unit.
- Reuses one narrow combinational leading-zero-count tree, CHUNK bits wide, over successive chunks, most significant chunk first.
- Terminates early on the first non-zero chunk.
- Sits between the issue stage and CLZ/normalization consumers, with valid/ready handshakes on both sides.

---
 rtl/clz_chunk_sequencer.sv | 147 ++++++++++++++
 tb/tb_clz_chunk_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clz_chunk_sequencer.sv
// Iterative leading-zero counter: one CHUNK-wide CLZ tree swept MSB-first over a WIDTH-bit operand.
// Optional macro CLZ_SEQ_NORM_EN adds o_out_norm (operand shifted so its leading 1 sits in bit WIDTH-1).
//   state | meaning
//   IDLE  | ready for an operand
//   SCAN  | examining one chunk per cycle, stops at first non-zero chunk
//   DONE  | result presented until consumer takes it
module clz_chunk_sequencer #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [WIDTH-1:0]           i_in_data,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [$clog2(WIDTH+1)-1:0] o_out_count,
`ifdef CLZ_SEQ_NORM_EN
    output logic [WIDTH-1:0]           o_out_norm,
`endif
    output logic                       o_out_zero
);

    localparam int CW     = $clog2(WIDTH+1);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LW     = $clog2(CHUNK+1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    r_idx;
    logic             r_zero;
    logic [CHUNK-1:0] w_top;
    logic [LW-1:0]    w_c;
    logic             w_hit;
    logic             w_last;

    function automatic logic [LW-1:0] f_clz(input logic [CHUNK-1:0] v);
        logic [LW-1:0] n;
        logic          found;
        n     = LW'(CHUNK);
        found = 1'b0;
        for (int i = CHUNK-1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = LW'(CHUNK-1-i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    assign w_top  = r_shift[WIDTH-1 -: CHUNK];
    assign w_c    = f_clz(w_top);
    assign w_hit  = (w_c != LW'(CHUNK));
    assign w_last = (r_idx == IW'(NCHUNK-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (i_in_valid)      w_next = S_SCAN;
                S_SCAN:  if (w_hit || w_last) w_next = S_DONE;
                S_DONE:  if (i_out_ready)     w_next = S_IDLE;
                default:                      w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready  = (r_state == S_IDLE);
        o_out_valid = (r_state == S_DONE);
        o_out_count = r_count;
        o_out_zero  = r_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_zero  <= 1'b0;
        end else if (i_flush) begin
            r_count <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_shift <= i_in_data;
                        r_count <= '0;
                        r_idx   <= '0;
                        r_zero  <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (w_hit) begin
                        r_count <= r_count + CW'(w_c);
                        r_zero  <= 1'b0;
                    end else if (w_last) begin
                        r_count <= CW'(WIDTH);
                        r_zero  <= 1'b1;
                    end else begin
                        r_count <= r_count + CW'(CHUNK);
                        r_shift <= r_shift << CHUNK;
                        r_idx   <= r_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CLZ_SEQ_NORM_EN
    logic [WIDTH-1:0] r_norm;

    // Earlier chunks are already shifted out, so only a sub-chunk shift remains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_norm <= '0;
        end else if (i_flush) begin
            r_norm <= '0;
        end else if (r_state == S_SCAN) begin
            if (w_hit)       r_norm <= r_shift << w_c;
            else if (w_last) r_norm <= '0;
        end
    end

    assign o_out_norm = r_norm;
`endif

    a_width_multiple: assert property (@(posedge clk) (WIDTH % CHUNK) == 0);
    a_chunk_pow2:     assert property (@(posedge clk) (CHUNK >= 2) && ((CHUNK & (CHUNK-1)) == 0));

endmodule

// File: tb/tb_clz_chunk_sequencer.sv
// Self-checking bench for clz_chunk_sequencer: directed cases plus randomized operands vs a bit-level model.
module tb_clz_chunk_sequencer;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 16;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = $clog2(WIDTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_flush;
    logic             i_in_valid;
    logic             o_in_ready;
    logic [WIDTH-1:0] i_in_data;
    logic             o_out_valid;
    logic             i_out_ready;
    logic [CW-1:0]    o_out_count;
    logic             o_out_zero;
`ifdef CLZ_SEQ_NORM_EN
    logic [WIDTH-1:0] o_out_norm;
`endif

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    clz_chunk_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flush     (i_flush),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_count (o_out_count),
`ifdef CLZ_SEQ_NORM_EN
        .o_out_norm  (o_out_norm),
`endif
        .o_out_zero  (o_out_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: scan bit by bit from the MSB.
    function automatic int ref_clz(input logic [WIDTH-1:0] v);
        for (int i = WIDTH-1; i >= 0; i--)
            if (v[i]) return WIDTH-1-i;
        return WIDTH;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] data, input int stall);
        int exp_cnt;
        int exp_lat;
        int lat;
        exp_cnt = ref_clz(data);
        exp_lat = (exp_cnt == WIDTH) ? NCHUNK : exp_cnt / CHUNK + 1;
        i_out_ready = (stall == 0);
        @(negedge clk);
        chk("in_ready_pre", o_in_ready, 1);
        i_in_valid = 1'b1;
        i_in_data  = data;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_in_data  = {$urandom, $urandom};
        lat = 0;
        while (lat < NCHUNK + 4) begin
            @(posedge clk); #1;
            lat++;
            if (o_out_valid) break;
        end
        chk("latency", lat, exp_lat);
        chk("out_valid", o_out_valid, 1);
        chk("count", o_out_count, exp_cnt);
        chk("zero", o_out_zero, exp_cnt == WIDTH);
`ifdef CLZ_SEQ_NORM_EN
        chk("norm", o_out_norm, data << exp_cnt);
`endif
        chk("in_ready_busy", o_in_ready, 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", o_out_valid, 1);
            chk("hold_count", o_out_count, exp_cnt);
            chk("hold_in_ready", o_in_ready, 0);
        end
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_in_ready", o_in_ready, 1);
        chk("post_valid", o_out_valid, 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_flush     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b1;
        #12;
        chk("rst_in_ready", o_in_ready, 1);
        chk("rst_valid", o_out_valid, 0);
        chk("rst_count", o_out_count, 0);
        chk("rst_zero", o_out_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(64'h8000_0000_0000_0000, 0);
        run_op(64'h0000_0000_0001_0000, 0);
        run_op(64'h0, 0);
        run_op(64'h0000_0F00_0000_0000, 5);
        run_op(64'h0000_0000_0000_0001, 1);

        // flush in the second SCAN cycle
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = 64'h1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("flush_scan_valid", o_out_valid, 0);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("flush_in_ready", o_in_ready, 1);
        chk("flush_valid", o_out_valid, 0);
        chk("flush_count", o_out_count, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("flush_no_valid", o_out_valid, 0);
        end
        run_op(64'h00FF_0000_0000_0000, 0);

        // flush in IDLE blocks the accept
        @(negedge clk);
        i_in_valid = 1'b1;
        i_flush    = 1'b1;
        i_in_data  = 64'h1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        i_flush    = 1'b0;
        chk("idle_flush_ready", o_in_ready, 1);
        @(posedge clk); #1;
        chk("idle_flush_valid", o_out_valid, 0);

        // flush together with out_ready in DONE discards and clears
        i_out_ready = 1'b0;
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = 64'h0000_0000_0000_00F0;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("done_valid", o_out_valid, 1);
        chk("done_count", o_out_count, 56);
        i_flush     = 1'b1;
        i_out_ready = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        chk("done_flush_valid", o_out_valid, 0);
        chk("done_flush_count", o_out_count, 0);
        chk("done_flush_ready", o_in_ready, 1);

        // asynchronous reset mid-SCAN
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_data  = 64'h1;
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_out_valid, 0);
        chk("arst_count", o_out_count, 0);
        chk("arst_zero", o_out_zero, 0);
        chk("arst_in_ready", o_in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'h0000_0000_8000_0000, 0);

        for (int n = 0; n < 40; n++) begin
            logic [WIDTH-1:0] d;
            d = {$urandom, $urandom};
            d = d >> $urandom_range(0, WIDTH);
            run_op(d, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
